uart_fifo_bridge: RTL and testbench

Buffered host-side front end for the UART serial cores. It holds host writes in a TX FIFO and launches them one at a time into the `tx` serializer with a start/done handshake. It also captures every byte the `rx` deserializer completes into an RX FIFO, read first-word-fall-through by the MMIO register block. It owns RX overrun detection and back-pressure toward `rx` through its `rx_full` input.

---
 rtl/uart_fifo_bridge.sv | 184 ++++++++++++++++++
 tb/tb_uart_fifo_bridge.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_bridge.sv
// rtl/uart_fifo_bridge.sv - buffered host front end between MMIO and the UART tx/rx cores
//
// uart_fifo_bridge ports:
//   clk, arst_n                      clock, synchronous active-low reset
//   wr_en, wr_data                   host push into the TX FIFO
//   tx_fifo_full/empty, tx_count     TX FIFO status
//   rd_en, rd_data                   host pop of the RX FIFO head (first-word-fall-through)
//   rx_fifo_full/empty, rx_count     RX FIFO status; rx_fifo_full also drives the rx core's rx_full
//   overrun, clr_overrun             sticky dropped-byte flag and its clear
//   tx_start, tx_din, tx_done, tx_idle   launch handshake with the tx core
//   rx_done_tick, rx_dout            completed byte from the rx core
//
// uart_fifo_bridge_fifo ports:
//   push/push_data, pop, head, full, empty, count -- circular FIFO, head reads 0 when empty

module uart_fifo_bridge_fifo #(
    parameter int W                  = 8,
    parameter int DEPTH              = 16,
    parameter bit PUSH_WHEN_FULL_POP = 1'b0
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          pop_ok;
    logic          push_ok;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    // A pop on an empty FIFO is ignored even when a push lands in the same cycle.
    assign pop_ok  = pop && !empty;
    // The RX side may accept a byte while full only because the head leaves in the same cycle.
    assign push_ok = push && (!full || (PUSH_WHEN_FULL_POP && pop_ok));

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            // Power-of-two depth: pointers wrap by natural overflow.
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (arst_n && push_ok) mem[wr_ptr] <= push_data;
    end

    assign head = empty ? '0 : mem[rd_ptr];
endmodule

module uart_fifo_bridge #(
    parameter int DATA_BITS = 8,
    parameter int TX_DEPTH  = 16,
    parameter int RX_DEPTH  = 16
) (
    input  logic                        clk,
    input  logic                        arst_n,
    input  logic                        wr_en,
    input  logic [DATA_BITS-1:0]        wr_data,
    output logic                        tx_fifo_full,
    output logic                        tx_fifo_empty,
    output logic [$clog2(TX_DEPTH):0]   tx_count,
    input  logic                        rd_en,
    output logic [DATA_BITS-1:0]        rd_data,
    output logic                        rx_fifo_full,
    output logic                        rx_fifo_empty,
    output logic [$clog2(RX_DEPTH):0]   rx_count,
    output logic                        overrun,
    input  logic                        clr_overrun,
    output logic                        tx_start,
    output logic [DATA_BITS-1:0]        tx_din,
    input  logic                        tx_done,
    input  logic                        tx_idle,
    input  logic                        rx_done_tick,
    input  logic [DATA_BITS-1:0]        rx_dout
);
    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t               state;
    logic                 launch;
    logic                 rx_drop;
    logic [DATA_BITS-1:0] tx_head;

    // Launch decision uses the registered empty flag, so a byte pushed this
    // cycle into an empty FIFO is only seen on the next cycle.
    assign launch = (state == S_IDLE) && !tx_fifo_empty && tx_idle;

    uart_fifo_bridge_fifo #(
        .W                  (DATA_BITS),
        .DEPTH              (TX_DEPTH),
        .PUSH_WHEN_FULL_POP (1'b0)
    ) u_tx_fifo (
        .clk       (clk),
        .arst_n    (arst_n),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (launch),
        .head      (tx_head),
        .full      (tx_fifo_full),
        .empty     (tx_fifo_empty),
        .count     (tx_count)
    );

    uart_fifo_bridge_fifo #(
        .W                  (DATA_BITS),
        .DEPTH              (RX_DEPTH),
        .PUSH_WHEN_FULL_POP (1'b1)
    ) u_rx_fifo (
        .clk       (clk),
        .arst_n    (arst_n),
        .push      (rx_done_tick),
        .push_data (rx_dout),
        .pop       (rd_en),
        .head      (rd_data),
        .full      (rx_fifo_full),
        .empty     (rx_fifo_empty),
        .count     (rx_count)
    );

    // Full implies non-empty, so rd_en alone decides whether the head frees a slot.
    assign rx_drop = rx_done_tick && rx_fifo_full && !rd_en;

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state    <= S_IDLE;
            tx_start <= 1'b0;
            tx_din   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (launch) begin
                        tx_din   <= tx_head;
                        tx_start <= 1'b1;
                        state    <= S_WAIT;
                    end else begin
                        tx_start <= 1'b0;
                    end
                end
                S_WAIT: begin
                    tx_start <= 1'b0;
                    if (tx_done) state <= S_IDLE;
                end
                default: begin
                    tx_start <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk) begin
        if (!arst_n)          overrun <= 1'b0;
        else if (rx_drop)     overrun <= 1'b1;
        else if (clr_overrun) overrun <= 1'b0;
    end
endmodule

// File: tb/tb_uart_fifo_bridge.sv
// tb/tb_uart_fifo_bridge.sv - directed self-checking bench for uart_fifo_bridge
module tb_uart_fifo_bridge;
    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic       tx_fifo_full, tx_fifo_empty;
    logic [4:0] tx_count;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       rx_fifo_full, rx_fifo_empty;
    logic [4:0] rx_count;
    logic       overrun;
    logic       clr_overrun = 1'b0;
    logic       tx_start;
    logic [7:0] tx_din;
    logic       tx_done = 1'b0;
    logic       tx_idle = 1'b1;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_dout = '0;

    int tests_run = 0;
    int tests_failed = 0;

    uart_fifo_bridge #(.DATA_BITS(8), .TX_DEPTH(16), .RX_DEPTH(16)) dut (
        .clk           (clk),
        .arst_n        (arst_n),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .tx_fifo_full  (tx_fifo_full),
        .tx_fifo_empty (tx_fifo_empty),
        .tx_count      (tx_count),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .rx_fifo_full  (rx_fifo_full),
        .rx_fifo_empty (rx_fifo_empty),
        .rx_count      (rx_count),
        .overrun       (overrun),
        .clr_overrun   (clr_overrun),
        .tx_start      (tx_start),
        .tx_din        (tx_din),
        .tx_done       (tx_done),
        .tx_idle       (tx_idle),
        .rx_done_tick  (rx_done_tick),
        .rx_dout       (rx_dout)
    );

    always #5 clk = ~clk;

    // Advance one cycle; inputs are changed and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_launch(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (tx_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        tick();
        tick();
        arst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++; if (tx_fifo_empty !== 1'b1 || rx_fifo_empty !== 1'b1) begin tests_failed++; $display("FAIL reset_empty tx=%b rx=%b expected 1 1", tx_fifo_empty, rx_fifo_empty); end
        tests_run++; if (tx_fifo_full !== 1'b0 || rx_fifo_full !== 1'b0) begin tests_failed++; $display("FAIL reset_full tx=%b rx=%b expected 0 0", tx_fifo_full, rx_fifo_full); end
        tests_run++; if (tx_start !== 1'b0 || tx_din !== 8'h00 || overrun !== 1'b0) begin tests_failed++; $display("FAIL reset_regs start=%b din=%h ovr=%b expected 0 00 0", tx_start, tx_din, overrun); end
        tests_run++; if (rd_data !== 8'h00 || tx_count !== 5'd0 || rx_count !== 5'd0) begin tests_failed++; $display("FAIL reset_data rd=%h txc=%0d rxc=%0d expected 00 0 0", rd_data, tx_count, rx_count); end
    endtask

    task automatic test_tx_basic();
        logic quiet;
        do_reset();
        tx_idle = 1'b1;
        // cycle 0 and 1: writes
        wr_en = 1'b1; wr_data = 8'hA5; tick();
        wr_data = 8'h3C; tick();
        wr_en = 1'b0;
        // cycle 2: first launch
        tests_run++; if (tx_start !== 1'b1 || tx_din !== 8'hA5) begin tests_failed++; $display("FAIL tx_first_launch start=%b din=%h expected 1 a5", tx_start, tx_din); end
        quiet = 1'b1;
        for (int c = 3; c < 22; c++) begin
            tick();
            if (tx_start !== 1'b0) quiet = 1'b0;
        end
        tests_run++; if (quiet !== 1'b1) begin tests_failed++; $display("FAIL tx_wait_quiet tx_start seen=%b expected 0", !quiet); end
        // cycle 22: tx_done
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        tests_run++; if (tx_start !== 1'b0 || tx_din !== 8'hA5) begin tests_failed++; $display("FAIL tx_idle_gap start=%b din=%h expected 0 a5", tx_start, tx_din); end
        tick();
        tests_run++; if (tx_start !== 1'b1 || tx_din !== 8'h3C) begin tests_failed++; $display("FAIL tx_second_launch start=%b din=%h expected 1 3c", tx_start, tx_din); end
        for (int c = 0; c < 20; c++) tick();
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        tests_run++; if (tx_fifo_empty !== 1'b1) begin tests_failed++; $display("FAIL tx_end_empty got=%b expected 1", tx_fifo_empty); end
    endtask

    task automatic test_tx_full_wrap();
        logic ok;
        logic quiet;
        tx_idle = 1'b0;
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1; wr_data = 8'(i); tick();
        end
        wr_en = 1'b0;
        tests_run++; if (tx_count !== 5'd16 || tx_fifo_full !== 1'b1) begin tests_failed++; $display("FAIL tx_full count=%0d full=%b expected 16 1", tx_count, tx_fifo_full); end
        tests_run++; if (tx_start !== 1'b0) begin tests_failed++; $display("FAIL tx_hold_not_idle start=%b expected 0", tx_start); end
        tx_idle = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wait_launch(ok);
            tests_run++; if (ok !== 1'b1 || tx_din !== 8'(i)) begin tests_failed++; $display("FAIL tx_order[%0d] launched=%b din=%h expected 1 %h", i, ok, tx_din, 8'(i)); end
            tx_done = 1'b1; tick(); tx_done = 1'b0;
        end
        quiet = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (tx_start !== 1'b0) quiet = 1'b0;
        end
        tests_run++; if (quiet !== 1'b1 || tx_fifo_empty !== 1'b1) begin tests_failed++; $display("FAIL tx_dropped_byte extra_launch=%b empty=%b expected 0 1", !quiet, tx_fifo_empty); end
    endtask

    task automatic test_rx_overrun();
        rx_done_tick = 1'b1; rx_dout = 8'h80; tick();
        rx_done_tick = 1'b0;
        tests_run++; if (rd_data !== 8'h80 || rx_count !== 5'd1) begin tests_failed++; $display("FAIL rx_latency rd=%h count=%0d expected 80 1", rd_data, rx_count); end
        for (int i = 1; i < 16; i++) begin
            rx_done_tick = 1'b1; rx_dout = 8'h80 + 8'(i); tick();
        end
        rx_dout = 8'hFF; tick();
        rx_done_tick = 1'b0;
        tests_run++; if (rx_fifo_full !== 1'b1 || rx_count !== 5'd16 || overrun !== 1'b1) begin tests_failed++; $display("FAIL rx_overrun full=%b count=%0d ovr=%b expected 1 16 1", rx_fifo_full, rx_count, overrun); end
        for (int i = 0; i < 16; i++) begin
            tests_run++; if (rd_data !== 8'h80 + 8'(i)) begin tests_failed++; $display("FAIL rx_read[%0d] got=%h expected %h", i, rd_data, 8'h80 + 8'(i)); end
            rd_en = 1'b1; tick(); rd_en = 1'b0;
        end
        tests_run++; if (rx_fifo_empty !== 1'b1 || rd_data !== 8'h00) begin tests_failed++; $display("FAIL rx_drained empty=%b rd=%h expected 1 00", rx_fifo_empty, rd_data); end
        clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;
        tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL rx_clr_overrun got=%b expected 0", overrun); end
    endtask

    task automatic test_rx_full_push_pop();
        for (int i = 0; i < 16; i++) begin
            rx_done_tick = 1'b1; rx_dout = 8'h90 + 8'(i); tick();
        end
        rx_dout = 8'h55; rd_en = 1'b1; tick();
        rx_done_tick = 1'b0; rd_en = 1'b0;
        tests_run++; if (overrun !== 1'b0 || rx_count !== 5'd16) begin tests_failed++; $display("FAIL rx_push_pop_full ovr=%b count=%0d expected 0 16", overrun, rx_count); end
        for (int i = 1; i < 17; i++) begin
            tests_run++; if (rd_data !== ((i == 16) ? 8'h55 : 8'h90 + 8'(i))) begin tests_failed++; $display("FAIL rx_pp_read[%0d] got=%h expected %h", i, rd_data, (i == 16) ? 8'h55 : 8'h90 + 8'(i)); end
            rd_en = 1'b1; tick(); rd_en = 1'b0;
        end
        tests_run++; if (rx_fifo_empty !== 1'b1) begin tests_failed++; $display("FAIL rx_pp_empty got=%b expected 1", rx_fifo_empty); end
    endtask

    task automatic test_rx_empty_push_pop();
        rd_en = 1'b1; rx_done_tick = 1'b1; rx_dout = 8'h77; tick();
        rd_en = 1'b0; rx_done_tick = 1'b0;
        tests_run++; if (rd_data !== 8'h77 || rx_count !== 5'd1) begin tests_failed++; $display("FAIL rx_empty_pop_ignored rd=%h count=%0d expected 77 1", rd_data, rx_count); end
        for (int i = 1; i < 16; i++) begin
            rx_done_tick = 1'b1; rx_dout = 8'(i); tick();
        end
        rx_dout = 8'hEE; clr_overrun = 1'b1; tick();
        rx_done_tick = 1'b0; clr_overrun = 1'b0;
        tests_run++; if (overrun !== 1'b1) begin tests_failed++; $display("FAIL rx_set_wins got=%b expected 1", overrun); end
    endtask

    task automatic test_reset_in_wait();
        logic quiet;
        logic ok;
        // RX holds 16 from previous test; drain 13 to leave 3.
        for (int i = 0; i < 13; i++) begin
            rd_en = 1'b1; tick();
        end
        rd_en = 1'b0;
        tx_idle = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = 8'hC0 + 8'(i); tick();
        end
        wr_en = 1'b0;
        tests_run++; if (tx_count !== 5'd3 || rx_count !== 5'd3) begin tests_failed++; $display("FAIL pre_reset_counts txc=%0d rxc=%0d expected 3 3", tx_count, rx_count); end
        tx_idle = 1'b0;
        arst_n = 1'b0; tick(); arst_n = 1'b1;
        tests_run++; if (tx_fifo_empty !== 1'b1 || rx_fifo_empty !== 1'b1 || tx_start !== 1'b0 || rd_data !== 8'h00) begin tests_failed++; $display("FAIL reset_in_wait txe=%b rxe=%b start=%b rd=%h expected 1 1 0 00", tx_fifo_empty, rx_fifo_empty, tx_start, rd_data); end
        tests_run++; if (overrun !== 1'b0 || tx_din !== 8'h00) begin tests_failed++; $display("FAIL reset_in_wait_regs ovr=%b din=%h expected 0 00", overrun, tx_din); end
        quiet = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (tx_start !== 1'b0) quiet = 1'b0;
        end
        tx_idle = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (tx_start !== 1'b0) quiet = 1'b0;
        end
        tests_run++; if (quiet !== 1'b1) begin tests_failed++; $display("FAIL reset_no_launch spurious=%b expected 0", !quiet); end
        wr_en = 1'b1; wr_data = 8'h42; tick(); wr_en = 1'b0;
        tests_run++; if (tx_start !== 1'b0) begin tests_failed++; $display("FAIL post_reset_n1 start=%b expected 0", tx_start); end
        tick();
        tests_run++; if (tx_start !== 1'b1 || tx_din !== 8'h42) begin tests_failed++; $display("FAIL post_reset_launch start=%b din=%h expected 1 42", tx_start, tx_din); end
        tick();
        wait_launch(ok);
        tests_run++; if (ok !== 1'b0) begin tests_failed++; $display("FAIL post_reset_single relaunch=%b expected 0", ok); end
    endtask

    initial begin
        test_reset();
        test_tx_basic();
        test_tx_full_wrap();
        test_rx_overrun();
        test_rx_full_push_pop();
        test_rx_empty_push_pop();
        test_reset_in_wait();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
